// File: rtl/pc_seq_pkg.sv
// Shared encodings for the next-PC sequencer: FSM states and
// next-PC source select.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2,
    ST_TRAP = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    SRC_SEQ  = 2'd0,
    SRC_BR   = 2'd1,
    SRC_TRAP = 2'd2,
    SRC_HOLD = 2'd3
  } pc_src_e;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/pc_redirect_arb.sv
// Priority select of the next-PC source and PC_IN value.
// PCSEQ_MISALIGN_TRAP_EN: misaligned branch targets raise a trap.
module pc_redirect_arb
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] TRAP_VEC = 32'h00400100
) (
  input  seq_state_e  state,
  input  logic [31:0] pc,
  input  logic        imem_rdy,
  input  logic        stall_d,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        trap_req,
  input  logic        halt_req,
  input  logic        timeout_hit,
  output pc_src_e     src,
  output logic [31:0] pc_in
);

  logic        br_bad;
  logic [31:0] br_pc;

  assign br_pc = br_target & 32'hFFFF_FFFC;

`ifdef PCSEQ_MISALIGN_TRAP_EN
  assign br_bad = br_taken && (br_target[1:0] != 2'b00);
`else
  assign br_bad = 1'b0;
`endif

  always_comb begin
    src = SRC_HOLD;
    unique case (state)
      ST_RUN, ST_WAIT: begin
        if (trap_req || timeout_hit || br_bad)
          src = SRC_TRAP;
        else if (br_taken)
          src = SRC_BR;
        else if (halt_req || stall_d || !imem_rdy)
          src = SRC_HOLD;
        else
          src = SRC_SEQ;
      end
      ST_HALT: begin
        if (trap_req)
          src = SRC_TRAP;
      end
      ST_TRAP: src = SRC_HOLD;
    endcase
  end

  always_comb begin
    pc_in = pc;
    unique case (src)
      SRC_SEQ:  pc_in = pc + PC_STEP;
      SRC_BR:   pc_in = br_pc;
      SRC_TRAP: pc_in = TRAP_VEC;
      SRC_HOLD: pc_in = pc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller: FSM, fetch watchdog, trap EPC capture.
// PCSEQ_MISALIGN_TRAP_EN: misaligned branch targets raise a trap.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] PC_INIT        = 32'h00400000,
  parameter logic [31:0] TRAP_VEC       = 32'h00400100,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic [31:0] PC,
  input  logic        IMEM_RDY,
  input  logic        STALL_D,
  input  logic        BR_TAKEN,
  input  logic [31:0] BR_TARGET,
  input  logic        TRAP_REQ,
  input  logic        HALT_REQ,
  input  logic        RESUME,
  output logic [31:0] PC_IN,
  output logic        WE_PC,
  output logic        FLUSH,
  output logic [1:0]  SEQ_STATE,
  output logic [31:0] TRAP_EPC,
  output logic        FETCH_TIMEOUT
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  seq_state_e    state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;
  pc_src_e       src;
  logic [31:0]   arb_pc;
  logic          timeout_hit;

  assign timeout_hit = (state_q == ST_WAIT) &&
                       (wait_q == CNT_LAST) && !IMEM_RDY;

  pc_redirect_arb #(
    .TRAP_VEC (TRAP_VEC)
  ) u_arb (
    .state       (state_q),
    .pc          (PC),
    .imem_rdy    (IMEM_RDY),
    .stall_d     (STALL_D),
    .br_taken    (BR_TAKEN),
    .br_target   (BR_TARGET),
    .trap_req    (TRAP_REQ),
    .halt_req    (HALT_REQ),
    .timeout_hit (timeout_hit),
    .src         (src),
    .pc_in       (arb_pc)
  );

  assign PC_IN     = RESETn ? arb_pc : PC_INIT;
  assign WE_PC     = !RESETn || (src != SRC_HOLD);
  assign FLUSH     = RESETn && (src == SRC_BR || src == SRC_TRAP);
  assign SEQ_STATE = state_q;

  // wait_cnt only survives consecutive fetch-wait cycles
  always_comb begin
    state_d = ST_RUN;
    wait_d  = '0;
    unique case (src)
      SRC_TRAP:        state_d = ST_TRAP;
      SRC_SEQ, SRC_BR: state_d = ST_RUN;
      SRC_HOLD: begin
        unique case (state_q)
          ST_HALT: state_d = RESUME ? ST_RUN : ST_HALT;
          ST_TRAP: state_d = ST_RUN;
          default: begin
            if (HALT_REQ) begin
              state_d = ST_HALT;
            end else if (!IMEM_RDY) begin
              state_d = ST_WAIT;
              wait_d  = (wait_q == CNT_LAST) ? wait_q
                                             : wait_q + 1'b1;
            end
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q       <= ST_RUN;
      wait_q        <= '0;
      TRAP_EPC      <= '0;
      FETCH_TIMEOUT <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (src == SRC_TRAP)
        TRAP_EPC <= PC;
      if (timeout_hit)
        FETCH_TIMEOUT <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed + randomized bench for pc_sequencer with a
// behavioural next-PC reference model.
module tb_pc_sequencer;

  localparam logic [31:0] P_INIT = 32'h00400000;
  localparam logic [31:0] P_TVEC = 32'h00400100;
  localparam int          P_TO   = 16;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic [31:0] PC = '0;
  logic        IMEM_RDY = 1'b1;
  logic        STALL_D = 1'b0;
  logic        BR_TAKEN = 1'b0;
  logic [31:0] BR_TARGET = '0;
  logic        TRAP_REQ = 1'b0;
  logic        HALT_REQ = 1'b0;
  logic        RESUME = 1'b0;
  logic [31:0] PC_IN;
  logic        WE_PC;
  logic        FLUSH;
  logic [1:0]  SEQ_STATE;
  logic [31:0] TRAP_EPC;
  logic        FETCH_TIMEOUT;

  int n_chk = 0;
  int n_fail = 0;

  // model: mode 0 run, 1 waiting for fetch, 2 halted, 3 trap
  int          m_mode = 0;
  int          m_waits = 0;
  logic [31:0] m_epc = '0;
  logic        m_to = 1'b0;
  logic [31:0] e_pc;
  logic        e_we;
  logic        e_fl;
  int          x_mode;
  int          x_waits;
  logic [31:0] x_epc;
  logic        x_to;

  pc_sequencer dut (
    .CLK           (CLK),
    .RESETn        (RESETn),
    .PC            (PC),
    .IMEM_RDY      (IMEM_RDY),
    .STALL_D       (STALL_D),
    .BR_TAKEN      (BR_TAKEN),
    .BR_TARGET     (BR_TARGET),
    .TRAP_REQ      (TRAP_REQ),
    .HALT_REQ      (HALT_REQ),
    .RESUME        (RESUME),
    .PC_IN         (PC_IN),
    .WE_PC         (WE_PC),
    .FLUSH         (FLUSH),
    .SEQ_STATE     (SEQ_STATE),
    .TRAP_EPC      (TRAP_EPC),
    .FETCH_TIMEOUT (FETCH_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic take_trap();
    e_pc    = P_TVEC;
    e_we    = 1'b1;
    e_fl    = 1'b1;
    x_mode  = 3;
    x_epc   = PC;
    x_waits = 0;
  endtask

  task automatic model();
    logic misal;
    logic dog;
    x_mode  = m_mode;
    x_waits = 0;
    x_epc   = m_epc;
    x_to    = m_to;
    e_pc    = PC;
    e_we    = 1'b0;
    e_fl    = 1'b0;
`ifdef PCSEQ_MISALIGN_TRAP_EN
    misal = BR_TAKEN && (BR_TARGET % 4 != 0);
`else
    misal = 1'b0;
`endif
    dog = (m_mode == 1) && (m_waits == P_TO - 1) && !IMEM_RDY;
    if (!RESETn) begin
      e_pc = P_INIT;
      e_we = 1'b1;
      x_mode = 0;
      x_epc = '0;
      x_to = 1'b0;
    end else if (m_mode == 3) begin
      x_mode = 0;
    end else if (m_mode == 2) begin
      if (TRAP_REQ) take_trap();
      else if (RESUME) x_mode = 0;
    end else if (TRAP_REQ || dog || misal) begin
      take_trap();
      if (dog) x_to = 1'b1;
    end else if (BR_TAKEN) begin
      e_pc = BR_TARGET - (BR_TARGET % 4);
      e_we = 1'b1;
      e_fl = 1'b1;
      x_mode = 0;
    end else if (HALT_REQ) begin
      x_mode = 2;
    end else if (!IMEM_RDY) begin
      x_mode = 1;
      x_waits = (m_waits + 1 > P_TO - 1) ? P_TO - 1 : m_waits + 1;
    end else if (STALL_D) begin
      x_mode = 0;
    end else begin
      e_pc = PC + 32'd4;
      e_we = 1'b1;
      x_mode = 0;
    end
  endtask

  task automatic step();
    #1;
    model();
    chk("pc_in", PC_IN, e_pc);
    chk("we_pc", {31'd0, WE_PC}, {31'd0, e_we});
    chk("flush", {31'd0, FLUSH}, {31'd0, e_fl});
    chk("seq_state", {30'd0, SEQ_STATE}, m_mode);
    chk("trap_epc", TRAP_EPC, m_epc);
    chk("fetch_timeout", {31'd0, FETCH_TIMEOUT}, {31'd0, m_to});
    @(posedge CLK);
    m_mode  = x_mode;
    m_waits = x_waits;
    m_epc   = x_epc;
    m_to    = x_to;
    @(negedge CLK);
  endtask

  task automatic idle();
    IMEM_RDY = 1'b1;
    STALL_D  = 1'b0;
    BR_TAKEN = 1'b0;
    TRAP_REQ = 1'b0;
    HALT_REQ = 1'b0;
    RESUME   = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    idle();
    @(negedge CLK);
    RESETn = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    step();
    chk("rst_state", {30'd0, SEQ_STATE}, 32'd0);
    RESETn = 1'b1;
    PC = 32'h00400000;
    #1 chk("t1_pc_in", PC_IN, 32'h00400004);
    step();
    PC = 32'h00400010;
    STALL_D = 1'b1;
    BR_TAKEN = 1'b1;
    BR_TARGET = 32'h00400040;
    #1 chk("t2_pc_in", PC_IN, 32'h00400040);
    step();
    idle();
    PC = 32'h00400020;
    TRAP_REQ = 1'b1;
    step();
    TRAP_REQ = 1'b0;
    PC = P_TVEC;
    #1 chk("t3_epc", TRAP_EPC, 32'h00400020);
    chk("t3_state", {30'd0, SEQ_STATE}, 32'd3);
    step();
    chk("t3_back", {30'd0, SEQ_STATE}, 32'd0);
    PC = 32'h00400200;
    IMEM_RDY = 1'b0;
    for (int i = 0; i < 16; i++) step();
    IMEM_RDY = 1'b1;
    chk("t4_timeout", {31'd0, FETCH_TIMEOUT}, 32'd1);
    step();
    PC = 32'h00400300;
    HALT_REQ = 1'b1;
    step();
    HALT_REQ = 1'b0;
    BR_TAKEN = 1'b1;
    BR_TARGET = 32'h00400500;
    #1 chk("t5_halt_we", {31'd0, WE_PC}, 32'd0);
    step();
    BR_TAKEN = 1'b0;
    RESUME = 1'b1;
    step();
    RESUME = 1'b0;
    chk("t5_resume", {30'd0, SEQ_STATE}, 32'd0);
    PC = 32'hFFFFFFFC;
    #1 chk("t6_wrap", PC_IN, 32'd0);
    step();
    PC = 32'h00400044;
    BR_TAKEN = 1'b1;
    BR_TARGET = 32'h00400042;
    step();
    idle();
    step();
    for (int i = 0; i < 800; i++) begin
      r = $urandom();
      PC = (r[4:0] == 0) ? 32'hFFFFFFFC : ($urandom() & 32'hFFFFFFFC);
      RESETn = ($urandom_range(0, 99) != 0);
      TRAP_REQ = ($urandom_range(0, 15) == 0);
      BR_TAKEN = ($urandom_range(0, 5) == 0);
      BR_TARGET = $urandom();
      HALT_REQ = ($urandom_range(0, 15) == 0);
      RESUME = ($urandom_range(0, 3) == 0);
      STALL_D = ($urandom_range(0, 3) == 0);
      IMEM_RDY = (i % 100 > 70 && i % 100 < 92) ? 1'b0
                 : ($urandom_range(0, 3) != 0);
      step();
    end
    idle();
    RESETn = 1'b0;
    step();
    RESETn = 1'b1;
    chk("final_to_clr", {31'd0, FETCH_TIMEOUT}, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
